axis_sdecompose: RTL and testbench



---
 rtl/axis_sdecompose.sv | 200 ++++++++++++++++++++
 tb/tb_axis_sdecompose.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sdecompose.sv
// axis_sdecompose: splits a signed tvalid-only sample stream into a slowly
// tracking coarse OFFSET stream and a saturated fine RESIDUAL stream.
// Pipeline: stage 1 registers the input, and stage 2 computes the residual,
// drives the outputs and advances the offset tracker.
// Build option: define AXIS_SDECOMPOSE_JAM_EN to load the offset with the
// first valid sample after reset. When it is undefined, the offset starts at
// 0 and is acquired by slewing only.
module axis_sdecompose #(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int RES_WIDTH         = 16,
  parameter int DEADBAND          = 16384,
  parameter int SLEW_STEP         = 256,
  parameter int SLEW_DIVIDER      = 8
) (
  input  logic                                a_clk,
  input  logic                                a_rst,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] S_AXIS_X_tdata,
  input  logic                                S_AXIS_X_tvalid,
  input  logic                                hold,
  output logic signed [SAXIS_TDATA_WIDTH-1:0] M_AXIS_OFFSET_tdata,
  output logic                                M_AXIS_OFFSET_tvalid,
  output logic signed [RES_WIDTH-1:0]         M_AXIS_RESIDUAL_tdata,
  output logic                                M_AXIS_RESIDUAL_tvalid,
  output logic                                res_saturated,
  output logic                                tracking
);

  localparam int XW = SAXIS_TDATA_WIDTH;
  localparam int CW = (SLEW_DIVIDER > 1) ? $clog2(SLEW_DIVIDER) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SLEW_DIVIDER - 1);

  // All thresholds are carried at residual precision (XW+1 bits, signed).
  localparam logic signed [XW:0] DB_HI   = (XW+1)'(DEADBAND);
  localparam logic signed [XW:0] DB_LO   = -DB_HI;
  localparam logic signed [XW:0] DB_HALF = (XW+1)'(DEADBAND / 2);
  localparam logic signed [XW:0] STEP    = (XW+1)'(SLEW_STEP);
  localparam logic signed [XW:0] RES_MAX = {{(XW-RES_WIDTH+2){1'b0}}, {(RES_WIDTH-1){1'b1}}};
  localparam logic signed [XW:0] RES_MIN = -RES_MAX;
  localparam logic signed [XW:0] OFF_MAX = {2'b00, {(XW-1){1'b1}}};
  localparam logic signed [XW:0] OFF_MIN = -OFF_MAX;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_LOCKED = 3'd1;
  localparam logic [2:0] ST_UP     = 3'd2;
  localparam logic [2:0] ST_DOWN   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // Stage 1
  logic signed [XW-1:0] x_r;
  logic                 v1;

  // Tracker state
  logic [2:0]           state, state_n;
  logic signed [XW-1:0] offset, offset_n;
  logic [CW-1:0]        cnt, cnt_n;

  // Stage-2 datapath
  logic signed [XW:0]          res_full;
  logic signed [XW:0]          off_ext, off_up, off_dn;
  logic signed [XW-1:0]        off_up_sat, off_dn_sat;
  logic signed [RES_WIDTH-1:0] res_clip;
  logic                        res_clipped;
  logic                        in_band, step_due;
  logic signed [XW-1:0]        out_off_c;
  logic signed [RES_WIDTH-1:0] out_res_c;
  logic                        out_sat_c;
  logic                        out_valid;

  // Stage 1: capture the sample and its valid flag.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      x_r <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= S_AXIS_X_tvalid;
      if (S_AXIS_X_tvalid) x_r <= S_AXIS_X_tdata;
    end
  end

  // Residual, residual clip and saturated offset step candidates.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    res_full    = {x_r[XW-1], x_r} - {offset[XW-1], offset};
    res_clip    = res_full[RES_WIDTH-1:0];
    res_clipped = 1'b0;
    if (res_full > RES_MAX) begin
      res_clip    = RES_MAX[RES_WIDTH-1:0];
      res_clipped = 1'b1;
    end else if (res_full < RES_MIN) begin
      res_clip    = RES_MIN[RES_WIDTH-1:0];
      res_clipped = 1'b1;
    end

    off_ext    = {offset[XW-1], offset};
    off_up     = off_ext + STEP;
    off_dn     = off_ext - STEP;
    off_up_sat = (off_up > OFF_MAX) ? OFF_MAX[XW-1:0] : off_up[XW-1:0];
    off_dn_sat = (off_dn < OFF_MIN) ? OFF_MIN[XW-1:0] : off_dn[XW-1:0];

    in_band  = (res_full <= DB_HALF) && (res_full >= -DB_HALF);
    step_due = (cnt == CNT_LAST);
  end

  // Tracker next state: jam beats hold, hold beats slewing, step before state change.
  always_comb begin
    state_n   = state;
    offset_n  = offset;
    cnt_n     = cnt;
    out_off_c = offset;
    out_res_c = res_clip;
    out_sat_c = res_clipped;
    case (state)
      ST_INIT: begin
        state_n = ST_LOCKED;
        cnt_n   = '0;
`ifdef AXIS_SDECOMPOSE_JAM_EN
        offset_n  = x_r;
        out_off_c = x_r;
        out_res_c = '0;
        out_sat_c = 1'b0;
`endif
      end
      ST_LOCKED: begin
        cnt_n = '0;
        if (hold)                 state_n = ST_HOLD;
        else if (res_full > DB_HI) state_n = ST_UP;
        else if (res_full < DB_LO) state_n = ST_DOWN;
      end
      ST_UP, ST_DOWN: begin
        if (hold) begin
          state_n = ST_HOLD;
        end else begin
          if (step_due) begin
            offset_n = (state == ST_UP) ? off_up_sat : off_dn_sat;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
          if (in_band) begin
            state_n = ST_LOCKED;
            cnt_n   = '0;
          end else if ((state == ST_UP) && (res_full < DB_LO)) begin
            state_n = ST_DOWN;
            cnt_n   = '0;
          end else if ((state == ST_DOWN) && (res_full > DB_HI)) begin
            state_n = ST_UP;
            cnt_n   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (!hold) begin
          state_n = ST_LOCKED;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_LOCKED;
        cnt_n   = '0;
      end
    endcase
  end

  // Tracker registers advance only on valid stage-2 samples.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state  <= ST_INIT;
      offset <= '0;
      cnt    <= '0;
    end else if (v1) begin
      state  <= state_n;
      offset <= offset_n;
      cnt    <= cnt_n;
    end
  end

  // Stage 2 output registers; valid is a pure delay, data holds across gaps.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      out_valid             <= 1'b0;
      M_AXIS_OFFSET_tdata   <= '0;
      M_AXIS_RESIDUAL_tdata <= '0;
      res_saturated         <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        M_AXIS_OFFSET_tdata   <= out_off_c;
        M_AXIS_RESIDUAL_tdata <= out_res_c;
        res_saturated         <= out_sat_c;
      end
    end
  end

  assign M_AXIS_OFFSET_tvalid   = out_valid;
  assign M_AXIS_RESIDUAL_tvalid = out_valid;
  assign tracking               = (state == ST_UP) || (state == ST_DOWN);

endmodule

// File: tb/tb_axis_sdecompose.sv
// tb_axis_sdecompose: randomized scoreboard bench for axis_sdecompose.
// The reference model tracks the offset with plain integer arithmetic per
// valid sample. A monitor compares every DUT output sample against the queue.
// Hold is only changed while the pipeline is empty, so the hold value seen at
// issue time is the value the tracker sees.
module tb_axis_sdecompose;

  localparam int XW = 32;
  localparam int RW = 16;

  localparam longint RMAX = 32767;
  localparam longint OMAX = 64'sd2147483647;
  localparam longint DB   = 16384;
  localparam longint STEP = 256;
  localparam int     DIV  = 8;

`ifdef AXIS_SDECOMPOSE_JAM_EN
  localparam longint BASE = 1000000;
`else
  localparam longint BASE = 0;
`endif

  logic                 a_clk = 1'b0;
  logic                 a_rst = 1'b1;
  logic signed [XW-1:0] s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 hold = 1'b0;
  logic signed [XW-1:0] off_data;
  logic                 off_valid;
  logic signed [RW-1:0] res_data;
  logic                 res_valid;
  logic                 res_sat;
  logic                 trk;

  always #5 a_clk = ~a_clk;

  axis_sdecompose #(
    .SAXIS_TDATA_WIDTH(XW),
    .RES_WIDTH        (RW),
    .DEADBAND         (16384),
    .SLEW_STEP        (256),
    .SLEW_DIVIDER     (DIV)
  ) dut (
    .a_clk                 (a_clk),
    .a_rst                 (a_rst),
    .S_AXIS_X_tdata        (s_data),
    .S_AXIS_X_tvalid       (s_valid),
    .hold                  (hold),
    .M_AXIS_OFFSET_tdata   (off_data),
    .M_AXIS_OFFSET_tvalid  (off_valid),
    .M_AXIS_RESIDUAL_tdata (res_data),
    .M_AXIS_RESIDUAL_tvalid(res_valid),
    .res_saturated         (res_sat),
    .tracking              (trk)
  );

  typedef struct {
    longint off;
    longint res;
    bit     sat;
    bit     trk;
  } exp_t;

  typedef enum {M_INIT, M_LOCK, M_UP, M_DN, M_HOLD} mode_t;

  exp_t   sb[$];
  mode_t  m_mode;
  longint m_off;
  int     m_cnt;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint clip(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_INIT;
    m_off  = 0;
    m_cnt  = 0;
    sb.delete();
  endtask

  // Reference: the output uses the offset before this sample's update.
  task automatic model_push(input longint x, input bit h);
    exp_t   e;
    longint r;
    r     = x - m_off;
    e.off = m_off;
    e.res = clip(r, RMAX);
    e.sat = (r > RMAX) || (r < -RMAX);
    case (m_mode)
      M_INIT: begin
`ifdef AXIS_SDECOMPOSE_JAM_EN
        m_off = x;
        e.off = x;
        e.res = 0;
        e.sat = 1'b0;
`endif
        m_mode = M_LOCK;
        m_cnt  = 0;
      end
      M_LOCK: begin
        if (h)            m_mode = M_HOLD;
        else if (r > DB)  m_mode = M_UP;
        else if (r < -DB) m_mode = M_DN;
      end
      M_HOLD: begin
        if (!h) begin
          m_mode = M_LOCK;
          m_cnt  = 0;
        end
      end
      default: begin
        if (h) begin
          m_mode = M_HOLD;
        end else begin
          m_cnt++;
          if (m_cnt == DIV) begin
            m_off = clip(m_off + ((m_mode == M_UP) ? STEP : -STEP), OMAX);
            m_cnt = 0;
          end
          if (r >= -(DB / 2) && r <= DB / 2) begin
            m_mode = M_LOCK;
            m_cnt  = 0;
          end else if (m_mode == M_UP && r < -DB) begin
            m_mode = M_DN;
            m_cnt  = 0;
          end else if (m_mode == M_DN && r > DB) begin
            m_mode = M_UP;
            m_cnt  = 0;
          end
        end
      end
    endcase
    e.trk = (m_mode == M_UP) || (m_mode == M_DN);
    sb.push_back(e);
  endtask

  task automatic send(input longint x);
    logic [63:0] xv;
    xv = x;
    @(posedge a_clk);
    #1;
    s_valid = 1'b1;
    s_data  = xv[XW-1:0];
    model_push(x, hold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge a_clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_offset"}, longint'(off_data), 0);
    check({tag, "_residual"}, longint'(res_data), 0);
    check({tag, "_off_valid"}, off_valid, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_saturated"}, res_sat, 0);
    check({tag, "_tracking"}, trk, 0);
  endtask

  // Monitor: output valid must be the input valid two clocks back; each
  // output sample is popped and compared with the scoreboard head.
  initial begin : monitor
    bit   h0, h1;
    exp_t e;
    h0 = 1'b0;
    h1 = 1'b0;
    forever begin
      @(negedge a_clk);
      if (a_rst) begin
        h0 = 1'b0;
        h1 = 1'b0;
      end else begin
        check("tvalid_pair", res_valid, off_valid);
        check("tvalid_delay", off_valid, h1);
        if (off_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow @%0t: got an output sample, expected none", $time);
          end else begin
            e = sb.pop_front();
            check("offset", longint'(off_data), e.off);
            check("residual", longint'(res_data), e.res);
            check("res_saturated", res_sat, e.sat);
            check("tracking", trk, e.trk);
          end
        end
        h1 = h0;
        h0 = s_valid;
      end
    end
  end

  initial begin : stimulus
    longint x;
    int     r;
    model_reset();
    a_rst = 1'b1;
    repeat (3) @(posedge a_clk);
    #1;
    check_zero("reset");
    a_rst = 1'b0;

    // Lock onto the base, then a +20000 step slews until back in band.
    repeat (4) send(BASE);
    repeat (450) send(BASE + 20000);

    // Large step saturates the residual; 5-cycle gaps land mid-slew.
    x = m_off + 100000;
    for (int i = 0; i < 2300; i++) begin
      if (i % 97 == 50) idle(5);
      send(x);
    end

    // Hold mid-slew, then release.
    x = m_off + 30000;
    repeat (20) send(x);
    idle(3);
    hold = 1'b1;
    for (int i = 0; i < 20; i++) send(x + longint'($urandom_range(0, 2000)));
    idle(3);
    hold = 1'b0;
    repeat (30) send(x);

    // Randomized traffic with gaps and hold toggles.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        send(m_off + longint'($urandom_range(0, 80000)) - 40000);
      end else if (r < 97) begin
        idle(1);
      end else begin
        idle(3);
        hold = ~hold;
      end
    end
    idle(3);
    hold = 1'b0;

    // Reset mid-slew with samples in flight.
    repeat (12) send(m_off + 30000);
    #2;
    a_rst   = 1'b1;
    s_valid = 1'b0;
    model_reset();
    #1;
    check_zero("midreset");
    repeat (2) @(posedge a_clk);
    #1;
    a_rst = 1'b0;
    send(-500);
    for (int i = 0; i < 20; i++) send(-500 + longint'($urandom_range(0, 1000)));

    idle(6);
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
